// File: rtl/instruction_fetch_ctrl.sv
// instruction_fetch_ctrl: multi-cycle fetch/decode/execute sequencer.
// Reads a 12-bit instruction ROM, latches the word, decodes it and issues
// one-cycle register-file / data-memory strobes to the datapath.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   run, step          free-run level / single-step pulse
//   im_addr, im_data   instruction memory read port (im_addr = pc)
//   instr, pc          latched instruction and program counter
//   rf_we/wa/ra1/ra2   register-file strobe and addresses
//   wd_sel, alu_op     write-data select (1 = ALU), ALU op (1 = sub)
//   dm_we, dm_addr     data-memory strobe and address
//   busy, halted       status; illegal is a sticky undefined-opcode flag
module instruction_fetch_ctrl #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned INSTR_W = 12,
  parameter int unsigned WRAP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic [INSTR_W-1:0] im_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               rf_we,
  output logic [2:0]         rf_wa,
  output logic [2:0]         rf_ra1,
  output logic [2:0]         rf_ra2,
  output logic               wd_sel,
  output logic               alu_op,
  output logic               dm_we,
  output logic [3:0]         dm_addr,
  output logic               busy,
  output logic               halted,
  output logic               illegal
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned RF_AW = 3;
  localparam int unsigned DM_AW = 4;

  localparam logic [OP_W-1:0]   OP_LOAD  = 3'b000;
  localparam logic [OP_W-1:0]   OP_STORE = 3'b001;
  localparam logic [OP_W-1:0]   OP_ADD   = 3'b101;
  localparam logic [OP_W-1:0]   OP_SUB   = 3'b110;
  localparam logic [ADDR_W-1:0] PC_LAST  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                step_mode_q, step_mode_d;
  logic                illegal_q, illegal_d;
  logic                rf_we_q, rf_we_d;
  logic                dm_we_q, dm_we_d;
  logic [RF_AW-1:0]    rf_wa_q, rf_wa_d;
  logic [RF_AW-1:0]    rf_ra1_q, rf_ra1_d;
  logic [RF_AW-1:0]    rf_ra2_q, rf_ra2_d;
  logic [DM_AW-1:0]    dm_addr_q, dm_addr_d;
  logic                wd_sel_q, wd_sel_d;
  logic                alu_op_q, alu_op_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;

  // Field decode of the word being fetched, so addresses are already
  // registered and stable when DECODE begins.
  logic [OP_W-1:0]  fetch_op;
  logic [RF_AW-1:0] dec_wa, dec_ra1, dec_ra2;
  logic [DM_AW-1:0] dec_dm_addr;
  logic             dec_wd_sel, dec_alu_op;

  always_comb begin
    fetch_op    = im_data[11:9];
    dec_ra1     = im_data[2:0];
    dec_ra2     = im_data[5:3];
    dec_dm_addr = im_data[3:0];
    dec_wa      = '0;
    dec_wd_sel  = 1'b0;
    dec_alu_op  = 1'b0;
    case (fetch_op)
      OP_LOAD:  dec_wa = im_data[6:4];
      OP_STORE: dec_ra1 = im_data[6:4];
      OP_ADD: begin
        dec_wa     = im_data[8:6];
        dec_wd_sel = 1'b1;
      end
      OP_SUB: begin
        dec_wa     = im_data[8:6];
        dec_wd_sel = 1'b1;
        dec_alu_op = 1'b1;
      end
      default: ;
    endcase
  end

  // Opcode of the latched instruction, used to arm the EXEC strobes.
  logic [OP_W-1:0] exec_op;
  logic            exec_rf_we, exec_dm_we, exec_bad;

  always_comb begin
    exec_op    = instr_q[11:9];
    exec_rf_we = (exec_op == OP_LOAD) || (exec_op == OP_ADD) || (exec_op == OP_SUB);
    exec_dm_we = (exec_op == OP_STORE);
    exec_bad   = !(exec_rf_we || exec_dm_we);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    step_mode_d = step_mode_q;
    illegal_d   = illegal_q;
    rf_we_d     = 1'b0;
    dm_we_d     = 1'b0;
    rf_wa_d     = rf_wa_q;
    rf_ra1_d    = rf_ra1_q;
    rf_ra2_d    = rf_ra2_q;
    dm_addr_d   = dm_addr_q;
    wd_sel_d    = wd_sel_q;
    alu_op_d    = alu_op_q;

    case (state_q)
      S_IDLE: begin
        // run has priority over step when both are high
        if (run) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b0;
        end else if (step) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
        end
      end
      S_FETCH: begin
        instr_d   = im_data;
        rf_wa_d   = dec_wa;
        rf_ra1_d  = dec_ra1;
        rf_ra2_d  = dec_ra2;
        dm_addr_d = dec_dm_addr;
        wd_sel_d  = dec_wd_sel;
        alu_op_d  = dec_alu_op;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // strobes become visible for exactly the EXEC cycle
        rf_we_d   = exec_rf_we;
        dm_we_d   = exec_dm_we;
        illegal_d = illegal_q | exec_bad;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        pc_d = pc_q + ADDR_W'(1);
        if ((WRAP == 0) && (pc_q == PC_LAST)) begin
          state_d = S_HALT;
        end else if (step_mode_q || !run) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);
    halted_d = (state_d == S_HALT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      step_mode_q <= 1'b0;
      illegal_q   <= 1'b0;
      rf_we_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      rf_ra1_q    <= '0;
      rf_ra2_q    <= '0;
      dm_addr_q   <= '0;
      wd_sel_q    <= 1'b0;
      alu_op_q    <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      step_mode_q <= step_mode_d;
      illegal_q   <= illegal_d;
      rf_we_q     <= rf_we_d;
      dm_we_q     <= dm_we_d;
      rf_wa_q     <= rf_wa_d;
      rf_ra1_q    <= rf_ra1_d;
      rf_ra2_q    <= rf_ra2_d;
      dm_addr_q   <= dm_addr_d;
      wd_sel_q    <= wd_sel_d;
      alu_op_q    <= alu_op_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  assign im_addr = pc_q;
  assign pc      = pc_q;
  assign instr   = instr_q;
  assign rf_we   = rf_we_q;
  assign dm_we   = dm_we_q;
  assign rf_wa   = rf_wa_q;
  assign rf_ra1  = rf_ra1_q;
  assign rf_ra2  = rf_ra2_q;
  assign dm_addr = dm_addr_q;
  assign wd_sel  = wd_sel_q;
  assign alu_op  = alu_op_q;
  assign busy    = busy_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Self-checking bench for instruction_fetch_ctrl: an instruction-level model
// predicts the fields and strobe of every executed instruction.
module tb_instruction_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        run_w = 1'b0;
  logic        step_w = 1'b0;
  logic [11:0] rom [8];

  logic [2:0]  im_addr, pc, rf_wa, rf_ra1, rf_ra2;
  logic [11:0] im_data, instr;
  logic        rf_we, wd_sel, alu_op, dm_we, busy, halted, illegal;
  logic [3:0]  dm_addr;

  logic [2:0]  im_addr_w, pc_w, rf_wa_w, rf_ra1_w, rf_ra2_w;
  logic [11:0] im_data_w, instr_w;
  logic        rf_we_w, wd_sel_w, alu_op_w, dm_we_w, busy_w, halted_w, illegal_w;
  logic [3:0]  dm_addr_w;

  assign im_data   = rom[im_addr];
  assign im_data_w = rom[im_addr_w];

  instruction_fetch_ctrl #(.ADDR_W(3), .INSTR_W(12), .WRAP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .im_addr(im_addr), .im_data(im_data), .instr(instr), .pc(pc),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
    .wd_sel(wd_sel), .alu_op(alu_op), .dm_we(dm_we), .dm_addr(dm_addr),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  instruction_fetch_ctrl #(.ADDR_W(3), .INSTR_W(12), .WRAP(0)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .run(run_w), .step(step_w),
    .im_addr(im_addr_w), .im_data(im_data_w), .instr(instr_w), .pc(pc_w),
    .rf_we(rf_we_w), .rf_wa(rf_wa_w), .rf_ra1(rf_ra1_w), .rf_ra2(rf_ra2_w),
    .wd_sel(wd_sel_w), .alu_op(alu_op_w), .dm_we(dm_we_w), .dm_addr(dm_addr_w),
    .busy(busy_w), .halted(halted_w), .illegal(illegal_w)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int mpc    = 0;
  logic millegal = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // {rf_we, dm_we, wd_sel, alu_op, rf_wa, rf_ra1, rf_ra2, dm_addr}
  function automatic logic [16:0] expect_dec(input logic [11:0] w);
    logic we, dw, wd, alu;
    logic [2:0] wa, ra1, ra2;
    logic [3:0] da;
    we = 1'b0; dw = 1'b0; wd = 1'b0; alu = 1'b0; wa = 3'd0;
    ra1 = w[2:0]; ra2 = w[5:3]; da = w[3:0];
    case (w[11:9])
      3'b000: begin we = 1'b1; wa = w[6:4]; end
      3'b001: begin dw = 1'b1; ra1 = w[6:4]; end
      3'b101: begin we = 1'b1; wa = w[8:6]; wd = 1'b1; end
      3'b110: begin we = 1'b1; wa = w[8:6]; wd = 1'b1; alu = 1'b1; end
      default: ;
    endcase
    return {we, dw, wd, alu, wa, ra1, ra2, da};
  endfunction

  function automatic logic is_bad(input logic [11:0] w);
    logic [2:0] op;
    op = w[11:9];
    return !(op == 3'b000 || op == 3'b001 || op == 3'b101 || op == 3'b110);
  endfunction

  // write-side fields only matter when a register write is expected
  function automatic logic [16:0] observe(input logic we);
    return {rf_we, dm_we, we & wd_sel, we & alu_op, we ? rf_wa : 3'd0,
            rf_ra1, rf_ra2, dm_addr};
  endfunction

  // Follows one instruction through FETCH/DECODE/EXEC; optionally drops run
  // or raises step (while busy) after the check in the given phase.
  task automatic exec_one(input int drop_ph, input int step_ph);
    logic [11:0] w;
    logic [16:0] e;
    logic bad;
    w   = rom[mpc];
    e   = expect_dec(w);
    bad = is_bad(w);
    for (int ph = 1; ph <= 3; ph++) begin
      @(negedge clk);
      if (ph == 1) begin
        check("fetch_busy", busy, 1);
        check("fetch_strobes", {rf_we, dm_we}, 0);
        check("fetch_pc", pc, mpc);
        check("fetch_illegal", illegal, millegal);
      end else if (ph == 2) begin
        check("dec_instr", instr, w);
        check("dec_fields", observe(e[16]), {2'b00, e[14:0]});
      end else begin
        check("exec_fields", observe(e[16]), e);
        check("exec_pc", pc, mpc);
        check("exec_illegal", illegal, millegal | bad);
      end
      step = (ph == step_ph);
      if (ph == drop_ph) run = 1'b0;
    end
    mpc      = (mpc + 1) % 8;
    millegal = millegal | bad;
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_strobes", {rf_we, dm_we}, 0);
      check("idle_pc", pc, mpc);
      check("idle_halted", halted, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; step = 1'b0; run_w = 1'b0;
    @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_instr", instr, 0);
    check("rst_illegal", illegal, 0);
    check("rst_status", {busy, halted}, 0);
    check("rst_fields", observe(1'b1), 0);
    check("rst_im_addr", im_addr, 0);
    rst_n    = 1'b1;
    mpc      = 0;
    millegal = 1'b0;
  endtask

  task automatic load_demo();
    rom[0] = 12'b000_00_001_0010;  // LOAD  r1 <- dm[2]
    rom[1] = 12'b000_00_000_0011;  // LOAD  r0 <- dm[3]
    rom[2] = 12'b101_010_001_000;  // ADD   r2 <- r1 + r0
    rom[3] = 12'b000_00_011_0100;  // LOAD  r3 <- dm[4]
    rom[4] = 12'b110_100_011_010;  // SUB   r4 <- r2 - r3
    rom[5] = 12'b001_00_001_0101;  // STORE dm[5] <- r1
    rom[6] = 12'b000_00_110_0111;  // LOAD  r6 <- dm[7]
    rom[7] = 12'b101_111_010_001;  // ADD   r7 <- r2 + r1
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int strobes;
    load_demo();

    // free-run through the demo program, across the pc wrap
    do_reset();
    @(negedge clk); run = 1'b1;
    for (int i = 0; i < 10; i++) exec_one((i == 9) ? 3 : 0, 0);
    idle_check(2);

    // undefined opcode at pc=2: NOP, sticky flag, pc advances
    rom[2] = 12'b011_000_000_000;
    do_reset();
    @(negedge clk); run = 1'b1;
    for (int i = 0; i < 4; i++) exec_one((i == 3) ? 3 : 0, 0);
    idle_check(1);
    check("illegal_sticky", illegal, 1);
    load_demo();

    // single-step: three pulses, with extra pulses while busy
    do_reset();
    idle_check(3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); step = 1'b1;
      exec_one(0, k);
      idle_check(2 + k);
    end
    check("step_pc", pc, 3);

    // run dropped during DECODE of the SUB at pc=4
    do_reset();
    @(negedge clk); run = 1'b1;
    for (int i = 0; i < 4; i++) exec_one(0, 0);
    exec_one(2, 0);
    idle_check(2);

    // async reset during EXEC of the STORE at pc=5
    do_reset();
    @(negedge clk); run = 1'b1;
    for (int i = 0; i < 5; i++) exec_one(0, 0);
    repeat (3) @(negedge clk);
    check("store_dm_we", dm_we, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_dm_we", dm_we, 0);
    check("rst_async_pc", pc, 0);
    check("rst_async_busy", busy, 0);
    run = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    mpc = 0; millegal = 1'b0;
    idle_check(2);

    // WRAP=0 instance: eight strobes then HALT
    do_reset();
    @(negedge clk); run_w = 1'b1;
    strobes = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      check("w0_strobe", rf_we_w | dm_we_w, (c % 3) == 0);
      check("w0_not_halted", halted_w, 0);
      if (rf_we_w | dm_we_w) strobes++;
    end
    @(negedge clk);
    check("w0_count", strobes, 8);
    check("w0_halted", halted_w, 1);
    check("w0_pc", pc_w, 0);
    check("w0_busy", busy_w, 0);
    repeat (12) begin
      @(negedge clk);
      check("w0_quiet", {rf_we_w, dm_we_w, busy_w}, 0);
      check("w0_stays_halted", halted_w, 1);
    end
    run_w = 1'b0;

    // randomized programs and run/step patterns
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) rom[i] = 12'($urandom);
      do_reset();
      for (int s = 0; s < 4; s++) begin
        if ($urandom_range(0, 1) == 1) begin
          n = $urandom_range(1, 6);
          @(negedge clk);
          run  = 1'b1;
          step = 1'($urandom_range(0, 1));
          for (int i = 0; i < n; i++)
            exec_one((i == n - 1) ? $urandom_range(1, 3) : 0, $urandom_range(0, 2));
        end else begin
          @(negedge clk); step = 1'b1;
          exec_one(0, $urandom_range(0, 2));
        end
        idle_check($urandom_range(1, 3));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_ctrl.md
Name: instruction_fetch_ctrl

Overview:
- Multi-cycle fetch/decode/execute controller; the reading end of the 12-bit-wide, 8-entry instruction memory.
- Drives the instruction address and latches the returned word.
- Decodes the opcode and issues one-cycle register-file and data-memory strobes to the datapath.
- Supports free-run and single-step (button) operation; sits between the instruction ROM and the register file / ALU / data memory.

Parameters:
ADDR_W, 3, instruction address width; program length is 2**ADDR_W.
INSTR_W, 12, instruction width; only 12 is supported.
WRAP, 1, 1 = PC wraps from last address to 0; 0 = enter HALT after the last instruction.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; continuous execution while high
step  in  1  one-cycle pulse; executes one instruction from IDLE
im_addr  out  ADDR_W  instruction memory read address (= pc)
im_data  in  12  instruction memory read data; combinational from im_addr
instr  out  12  latched current instruction
pc  out  ADDR_W  program counter
rf_we  out  1  register-file write strobe
rf_wa  out  3  register-file write address
rf_ra1  out  3  register-file read address 1
rf_ra2  out  3  register-file read address 2
wd_sel  out  1  RF write-data select: 0 = data memory, 1 = ALU
alu_op  out  1  0 = add (rd1+rd2), 1 = sub (rd1-rd2)
dm_we  out  1  data-memory write strobe
dm_addr  out  4  data-memory address
busy  out  1  high in FETCH, DECODE and EXEC
halted  out  1  high in HALT
illegal  out  1  sticky; set on an undefined opcode

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; pc=0; instr=0; illegal=0.
  - All strobes and address outputs 0.
  - Reset mid-instruction aborts with no strobe issued.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE:
  - run=1 -> FETCH.
  - step=1 with run=0 -> FETCH in single-step mode; mode is held for exactly one instruction.
  - Otherwise remain in IDLE.
- FETCH: im_addr=pc; instr<=im_data at the end of the cycle -> DECODE.
- DECODE (registered decode of instr):
  - rf_ra1=instr[2:0], rf_ra2=instr[5:3], dm_addr=instr[3:0].
  - -> EXEC.
- EXEC:
  - Issues exactly one cycle of strobes per the opcode table below.
  - End of cycle: pc<=pc+1 modulo 2**ADDR_W.
  - Next state:
    - HALT if WRAP=0 and pc was the last address.
    - Else IDLE if single-step or run=0.
    - Else FETCH.
- Opcode table, op = instr[11:9]:
  - 000 LOAD: rf[instr[6:4]] <= dm[instr[3:0]]. rf_we=1, rf_wa=instr[6:4], wd_sel=0, dm_addr=instr[3:0].
  - 001 STORE: dm[instr[3:0]] <= rf[instr[6:4]]. dm_we=1, rf_ra1=instr[6:4], dm_addr=instr[3:0].
  - 101 ADD: rf[instr[8:6]] <= rf[instr[5:3]] + rf[instr[2:0]]. rf_we=1, rf_wa=instr[8:6], wd_sel=1, alu_op=0.
  - 110 SUB: rf[instr[8:6]] <= rf[instr[2:0]] - rf[instr[5:3]]. Same as ADD with alu_op=1; rf_ra1=instr[2:0], rf_ra2=instr[5:3].
  - Any other opcode: no strobes (NOP), illegal<=1, pc still advances.
- Arithmetic wraps at the datapath width; this block issues no carry/overflow signals.
- rf_we and dm_we are never both high; neither is high outside EXEC.
- Address outputs are stable from DECODE through EXEC.
- Latency and throughput: 3 cycles per instruction in run mode; strobe in the 3rd cycle after entering FETCH.
- run falling mid-instruction: the current instruction completes, then IDLE.
- step while busy is ignored. run and step both high in IDLE: run mode wins.
- HALT is left only by reset.

Test Plan:
- Reset, then run=1 with the 8-word demo program: strobes occur on cycles 3, 6, 9, …. Order is rf_we(wa=1), rf_we(wa=0), rf_we(wa=2, alu add), rf_we(wa=3), rf_we(wa=4, alu_op=1), dm_we(dm_addr=5, ra1=1), rf_we(wa=6, wd_sel=0), rf_we(wa=7). Then pc wraps to 0.
- WRAP=0: after the 8th EXEC -> halted=1, pc=0, no further strobes while run remains high.
- Single step: run=0, pulse step 3 times with gaps -> exactly 3 instructions execute, pc=3, state returns to IDLE after each; step pulses during busy are ignored.
- Instruction 12'b011_000_000_000 at pc=2 -> no strobes, illegal=1 sticky, pc advances to 3.
- Drop run during DECODE of pc=4 -> SUB strobe still issued, pc=5, IDLE, busy=0.
- Assert rst_n=0 during EXEC of STORE -> dm_we falls immediately (async); pc=0, IDLE after release.
